// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with load-use hazard detection and operand forwarding
// Ports: clk_i/rst_i clock and sync active-high reset; flush_i kills the instruction entering EX;
//        hold_i freezes the stage; dec_* decoded instruction and register-file data;
//        exm_*/wb_* younger results available for forwarding; stall_o holds decode/fetch;
//        a_o/b_o/st_data_o forwarded operands; alu_op_o, imm_o, pc_o, rd_o and qualified control.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic            dec_valid_i,
   input  logic [RA_W-1:0] dec_rs1_i,
   input  logic [RA_W-1:0] dec_rs2_i,
   input  logic            dec_use_rs1_i,
   input  logic            dec_use_rs2_i,
   input  logic [XLEN-1:0] dec_rs1_data_i,
   input  logic [XLEN-1:0] dec_rs2_data_i,
   input  logic [XLEN-1:0] dec_imm_i,
   input  logic            dec_use_imm_i,
   input  logic [3:0]      dec_alu_op_i,
   input  logic [RA_W-1:0] dec_rd_i,
   input  logic            dec_reg_we_i,
   input  logic            dec_mem_rd_i,
   input  logic            dec_mem_wr_i,
   input  logic [XLEN-1:0] dec_pc_i,
   input  logic [RA_W-1:0] exm_rd_i,
   input  logic            exm_we_i,
   input  logic [XLEN-1:0] exm_data_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_we_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            stall_o,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o,
   output logic [3:0]      alu_op_o,
   output logic [XLEN-1:0] st_data_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] pc_o,
   output logic [RA_W-1:0] rd_o,
   output logic            valid_o,
   output logic            reg_we_o,
   output logic            mem_rd_o,
   output logic            mem_wr_o
);

   logic            valid_q, reg_we_q, mem_rd_q, mem_wr_q, use_imm_q;
   logic [3:0]      alu_op_q;
   logic [RA_W-1:0] rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;

   logic            exm_ok, wb_ok, hazard;
   logic [XLEN-1:0] cap_rs1_data, cap_rs2_data;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   // Forwarding sources are treated as invalid while reset is asserted.
   assign exm_ok = exm_we_i & ~rst_i & (exm_rd_i != '0);
   assign wb_ok  = wb_we_i  & ~rst_i & (wb_rd_i  != '0);

   // A load in EX cannot supply its data until WB, so a dependent instruction waits one cycle.
   assign hazard = valid_q & mem_rd_q & (rd_q != '0) & dec_valid_i &
                   ((dec_use_rs1_i & (dec_rs1_i == rd_q)) | (dec_use_rs2_i & (dec_rs2_i == rd_q)));

   assign stall_o = ~rst_i & (hazard | hold_i);

   // WB writes the register file in the same cycle decode reads it; take the new value.
   assign cap_rs1_data = (wb_ok && wb_rd_i == dec_rs1_i) ? wb_data_i : dec_rs1_data_i;
   assign cap_rs2_data = (wb_ok && wb_rd_i == dec_rs2_i) ? wb_data_i : dec_rs2_data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         reg_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         use_imm_q  <= 1'b0;
         alu_op_q   <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
      end else if (flush_i || (!hold_i && hazard)) begin
         valid_q  <= 1'b0;
         reg_we_q <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         alu_op_q <= '0;
      end else if (!hold_i) begin
         valid_q    <= dec_valid_i;
         reg_we_q   <= dec_reg_we_i & dec_valid_i;
         mem_rd_q   <= dec_mem_rd_i & dec_valid_i;
         mem_wr_q   <= dec_mem_wr_i & dec_valid_i;
         use_imm_q  <= dec_use_imm_i;
         alu_op_q   <= dec_alu_op_i;
         rd_q       <= dec_rd_i;
         rs1_q      <= dec_rs1_i;
         rs2_q      <= dec_rs2_i;
         rs1_data_q <= cap_rs1_data;
         rs2_data_q <= cap_rs2_data;
         imm_q      <= dec_imm_i;
         pc_q       <= dec_pc_i;
      end
   end

   // EX/MEM holds the younger result, so it wins over WB.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exm_ok && exm_rd_i == rs1_q)
         fwd_rs1 = exm_data_i;
      else if (wb_ok && wb_rd_i == rs1_q)
         fwd_rs1 = wb_data_i;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exm_ok && exm_rd_i == rs2_q)
         fwd_rs2 = exm_data_i;
      else if (wb_ok && wb_rd_i == rs2_q)
         fwd_rs2 = wb_data_i;
   end

   assign a_o       = fwd_rs1;
   assign b_o       = use_imm_q ? imm_q : fwd_rs2;
   assign st_data_o = fwd_rs2;
   assign alu_op_o  = alu_op_q;
   assign imm_o     = imm_q;
   assign pc_o      = pc_q;
   assign rd_o      = rd_q;
   assign valid_o   = valid_q;
   assign reg_we_o  = reg_we_q;
   assign mem_rd_o  = mem_rd_q;
   assign mem_wr_o  = mem_wr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_i, flush_i, hold_i, dec_valid_i;
   logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i, exm_rd_i, wb_rd_i;
   logic        dec_use_rs1_i, dec_use_rs2_i, dec_use_imm_i;
   logic [31:0] dec_rs1_data_i, dec_rs2_data_i, dec_imm_i, dec_pc_i, exm_data_i, wb_data_i;
   logic [3:0]  dec_alu_op_i;
   logic        dec_reg_we_i, dec_mem_rd_i, dec_mem_wr_i, exm_we_i, wb_we_i;
   logic        stall_o, valid_o, reg_we_o, mem_rd_o, mem_wr_o;
   logic [31:0] a_o, b_o, st_data_o, imm_o, pc_o;
   logic [3:0]  alu_op_o;
   logic [4:0]  rd_o;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i),
      .dec_valid_i(dec_valid_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
      .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
      .dec_rs1_data_i(dec_rs1_data_i), .dec_rs2_data_i(dec_rs2_data_i),
      .dec_imm_i(dec_imm_i), .dec_use_imm_i(dec_use_imm_i), .dec_alu_op_i(dec_alu_op_i),
      .dec_rd_i(dec_rd_i), .dec_reg_we_i(dec_reg_we_i), .dec_mem_rd_i(dec_mem_rd_i),
      .dec_mem_wr_i(dec_mem_wr_i), .dec_pc_i(dec_pc_i),
      .exm_rd_i(exm_rd_i), .exm_we_i(exm_we_i), .exm_data_i(exm_data_i),
      .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_data_i(wb_data_i),
      .stall_o(stall_o), .a_o(a_o), .b_o(b_o), .alu_op_o(alu_op_o), .st_data_o(st_data_o),
      .imm_o(imm_o), .pc_o(pc_o), .rd_o(rd_o), .valid_o(valid_o), .reg_we_o(reg_we_o),
      .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the instruction occupying EX.
   typedef struct {
      bit        valid, reg_we, mem_rd, mem_wr, use_imm;
      bit [3:0]  alu_op;
      bit [4:0]  rd, rs1, rs2;
      bit [31:0] d1, d2, imm, pc;
   } ex_t;
   ex_t ex;

   function automatic bit m_hazard();
      return ex.valid && ex.mem_rd && ex.rd != 0 && dec_valid_i &&
             ((dec_use_rs1_i && dec_rs1_i == ex.rd) || (dec_use_rs2_i && dec_rs2_i == ex.rd));
   endfunction

   // Newest available value of a register: EX/MEM, then WB, then what was latched.
   function automatic logic [31:0] m_value(input logic [4:0] idx, input logic [31:0] lat);
      if (idx == 0 || rst_i) return lat;
      if (exm_we_i && exm_rd_i == idx) return exm_data_i;
      if (wb_we_i && wb_rd_i == idx) return wb_data_i;
      return lat;
   endfunction

   function automatic logic [31:0] m_regread(input logic [4:0] idx, input logic [31:0] rf);
      if (idx != 0 && wb_we_i && wb_rd_i == idx) return wb_data_i;
      return rf;
   endfunction

   always @(posedge clk) begin
      ex_t nx;
      nx = ex;
      if (rst_i) begin
         nx = '{default: 0};
      end else if (flush_i || (!hold_i && m_hazard())) begin
         nx.valid = 0; nx.reg_we = 0; nx.mem_rd = 0; nx.mem_wr = 0; nx.alu_op = 0;
      end else if (!hold_i) begin
         nx.valid   = dec_valid_i;
         nx.reg_we  = dec_reg_we_i && dec_valid_i;
         nx.mem_rd  = dec_mem_rd_i && dec_valid_i;
         nx.mem_wr  = dec_mem_wr_i && dec_valid_i;
         nx.use_imm = dec_use_imm_i;
         nx.alu_op  = dec_alu_op_i;
         nx.rd      = dec_rd_i;
         nx.rs1     = dec_rs1_i;
         nx.rs2     = dec_rs2_i;
         nx.d1      = m_regread(dec_rs1_i, dec_rs1_data_i);
         nx.d2      = m_regread(dec_rs2_i, dec_rs2_data_i);
         nx.imm     = dec_imm_i;
         nx.pc      = dec_pc_i;
      end
      ex = nx;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_stall", {31'b0, stall_o}, {31'b0, !rst_i && (m_hazard() || hold_i)});
         chk("m_valid", {31'b0, valid_o}, {31'b0, ex.valid});
         chk("m_reg_we", {31'b0, reg_we_o}, {31'b0, ex.reg_we});
         chk("m_mem_rd", {31'b0, mem_rd_o}, {31'b0, ex.mem_rd});
         chk("m_mem_wr", {31'b0, mem_wr_o}, {31'b0, ex.mem_wr});
         chk("m_alu_op", {28'b0, alu_op_o}, {28'b0, ex.alu_op});
         chk("m_rd", {27'b0, rd_o}, {27'b0, ex.rd});
         chk("m_a", a_o, m_value(ex.rs1, ex.d1));
         chk("m_b", b_o, ex.use_imm ? ex.imm : m_value(ex.rs2, ex.d2));
         chk("m_st_data", st_data_o, m_value(ex.rs2, ex.d2));
         chk("m_imm", imm_o, ex.imm);
         chk("m_pc", pc_o, ex.pc);
      end
   end

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic clr_all();
      flush_i = 0; hold_i = 0; dec_valid_i = 0;
      dec_rs1_i = 0; dec_rs2_i = 0; dec_use_rs1_i = 0; dec_use_rs2_i = 0;
      dec_rs1_data_i = 0; dec_rs2_data_i = 0; dec_imm_i = 0; dec_use_imm_i = 0;
      dec_alu_op_i = 0; dec_rd_i = 0; dec_reg_we_i = 0; dec_mem_rd_i = 0; dec_mem_wr_i = 0;
      dec_pc_i = 0; exm_rd_i = 0; exm_we_i = 0; exm_data_i = 0;
      wb_rd_i = 0; wb_we_i = 0; wb_data_i = 0;
   endtask

   task automatic dec_alu(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                          input logic [31:0] d2, input logic [4:0] rd, input logic [3:0] op);
      dec_valid_i = 1; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_use_rs1_i = 1; dec_use_rs2_i = 1;
      dec_rs1_data_i = d1; dec_rs2_data_i = d2; dec_rd_i = rd; dec_alu_op_i = op;
      dec_reg_we_i = 1; dec_mem_rd_i = 0; dec_mem_wr_i = 0; dec_use_imm_i = 0;
      dec_imm_i = 0; dec_pc_i = dec_pc_i + 4;
   endtask

   initial begin
      clr_all();
      rst_i = 1; hold_i = 1;
      adv();
      chk_en = 1;
      settle();
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_stall_with_hold", {31'b0, stall_o}, 32'd0);
      chk("rst_alu_op", {28'b0, alu_op_o}, 32'd0);

      // Plain add.
      rst_i = 0; hold_i = 0;
      dec_alu(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'b0001);
      adv(); settle();
      chk("add_valid", {31'b0, valid_o}, 32'd1);
      chk("add_a", a_o, 32'd5);
      chk("add_b", b_o, 32'd7);
      chk("add_op", {28'b0, alu_op_o}, 32'd1);

      // EX/MEM over WB priority, then WB alone, then x0 never forwarded.
      dec_alu(5'd3, 32'h99, 5'd2, 32'h1, 5'd5, 4'b0001);
      adv();
      dec_valid_i = 0;
      exm_we_i = 1; exm_rd_i = 3; exm_data_i = 32'h10;
      wb_we_i = 1; wb_rd_i = 3; wb_data_i = 32'h20;
      settle();
      chk("fwd_exm", a_o, 32'h10);
      exm_we_i = 0; #1;
      chk("fwd_wb", a_o, 32'h20);
      exm_we_i = 1; exm_rd_i = 0; wb_rd_i = 0;
      dec_alu(5'd0, 32'h77, 5'd2, 32'h1, 5'd5, 4'b0001);
      adv(); settle();
      chk("fwd_x0", a_o, 32'h77);

      // Load-use: one bubble, then WB supplies the loaded value.
      exm_we_i = 0; wb_we_i = 0;
      dec_alu(5'd1, 32'h100, 5'd0, 32'h0, 5'd4, 4'b0001);
      dec_mem_rd_i = 1; dec_use_imm_i = 1; dec_imm_i = 32'd8;
      adv();
      dec_alu(5'd1, 32'h100, 5'd4, 32'hDEAD, 5'd6, 4'b0001);
      settle();
      chk("lu_stall", {31'b0, stall_o}, 32'd1);
      adv();
      exm_we_i = 1; exm_rd_i = 4; exm_data_i = 32'h108;
      settle();
      chk("lu_bubble_valid", {31'b0, valid_o}, 32'd0);
      chk("lu_bubble_we", {31'b0, reg_we_o}, 32'd0);
      chk("lu_stall_done", {31'b0, stall_o}, 32'd0);
      adv();
      dec_valid_i = 0; exm_we_i = 0;
      wb_we_i = 1; wb_rd_i = 4; wb_data_i = 32'hABCD;
      settle();
      chk("lu_valid", {31'b0, valid_o}, 32'd1);
      chk("lu_b", b_o, 32'hABCD);

      // Load to x0 never stalls.
      wb_we_i = 0;
      dec_alu(5'd1, 32'h0, 5'd0, 32'h0, 5'd0, 4'b0001);
      dec_mem_rd_i = 1;
      adv();
      dec_alu(5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 4'b0001);
      settle();
      chk("x0_no_stall", {31'b0, stall_o}, 32'd0);

      // Store with immediate.
      dec_alu(5'd1, 32'h0, 5'd7, 32'h11, 5'd0, 4'b0000);
      dec_reg_we_i = 0; dec_mem_wr_i = 1; dec_use_imm_i = 1; dec_imm_i = 32'hFFFFFFF0;
      adv();
      dec_valid_i = 0;
      exm_we_i = 1; exm_rd_i = 7; exm_data_i = 32'h55;
      settle();
      chk("st_b", b_o, 32'hFFFFFFF0);
      chk("st_data", st_data_o, 32'h55);
      chk("st_mem_wr", {31'b0, mem_wr_o}, 32'd1);

      // Hold for three cycles, then flush together with hold.
      exm_we_i = 0;
      dec_alu(5'd1, 32'h3, 5'd2, 32'h4, 5'd8, 4'b0010);
      adv();
      dec_alu(5'd1, 32'h9, 5'd2, 32'h9, 5'd9, 4'b0011);
      hold_i = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("hold_stall", {31'b0, stall_o}, 32'd1);
         chk("hold_op", {28'b0, alu_op_o}, 32'd2);
         chk("hold_rd", {27'b0, rd_o}, 32'd8);
         adv();
      end
      flush_i = 1;
      adv(); settle();
      chk("flush_valid", {31'b0, valid_o}, 32'd0);
      flush_i = 0; hold_i = 0;

      // Reset mid-stream.
      dec_alu(5'd1, 32'h1, 5'd2, 32'h2, 5'd10, 4'b0101);
      adv(); settle();
      chk("pre_rst_valid", {31'b0, valid_o}, 32'd1);
      rst_i = 1; hold_i = 1;
      #1;
      chk("rst_mid_stall", {31'b0, stall_o}, 32'd0);
      adv(); settle();
      chk("rst_mid_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_mid_rd", {27'b0, rd_o}, 32'd0);
      rst_i = 0; hold_i = 0;
      dec_alu(5'd1, 32'h9, 5'd2, 32'h3, 5'd11, 4'b0001);
      adv(); settle();
      chk("post_rst_a", a_o, 32'h9);
      chk("post_rst_b", b_o, 32'h3);
      chk("post_rst_valid", {31'b0, valid_o}, 32'd1);

      // Mixed traffic with small indices so hazards and forwards occur often.
      for (int i = 0; i < 200; i++) begin
         rst_i          = ($urandom_range(0, 39) == 0);
         flush_i        = ($urandom_range(0, 7) == 0);
         hold_i         = ($urandom_range(0, 5) == 0);
         dec_valid_i    = ($urandom_range(0, 3) != 0);
         dec_rs1_i      = 5'($urandom_range(0, 3));
         dec_rs2_i      = 5'($urandom_range(0, 3));
         dec_use_rs1_i  = 1'($urandom);
         dec_use_rs2_i  = 1'($urandom);
         dec_rs1_data_i = $urandom;
         dec_rs2_data_i = $urandom;
         dec_imm_i      = $urandom;
         dec_use_imm_i  = 1'($urandom);
         dec_alu_op_i   = 4'($urandom);
         dec_rd_i       = 5'($urandom_range(0, 3));
         dec_reg_we_i   = 1'($urandom);
         dec_mem_rd_i   = ($urandom_range(0, 2) == 0);
         dec_mem_wr_i   = 1'($urandom);
         dec_pc_i       = $urandom;
         exm_rd_i       = 5'($urandom_range(0, 3));
         exm_we_i       = 1'($urandom);
         exm_data_i     = $urandom;
         wb_rd_i        = 5'($urandom_range(0, 3));
         wb_we_i        = 1'($urandom);
         wb_data_i      = $urandom;
         settle();
         adv();
      end

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
